lif_array: RTL

Parametrised successor to the single 8-bit LIF neuron. It holds N_NEURONS independent leaky integrate-and-fire neurons that advance together on a shared time-step strobe.
- Leak is a configurable right-shift (beta = 2^-BETA_SHIFT).
- Integration saturates instead of wrapping.
- Threshold and reset mode are runtime-programmable.
- Each neuron has a refractory period after it fires.
- Sits between the input-current encoder and the spike-routing logic of the SNN demo datapath.

---
 rtl/lif_pkg.sv | 12 +
 rtl/lif_neuron_core.sv | 61 ++++++
 rtl/lif_array.sv | 56 +++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

    localparam logic LIF_RST_ZERO = 1'b0;
    localparam logic LIF_RST_SUB  = 1'b1;

    // Width of a counter that must hold 0..cycles; never narrower than one bit.
    function automatic int refrac_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One LIF neuron: saturating leaky integration, threshold spike, reset mode and
// refractory hold, advanced only on the shared step strobe.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int BETA_SHIFT    = 1,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] thresh,
    input  logic             mode,
    output logic             spike,
    output logic [WIDTH-1:0] state,
    output logic             refrac
);

    localparam int                 CNT_W       = refrac_cnt_width(REFRAC_CYCLES);
    localparam logic [CNT_W-1:0]   REFRAC_LOAD = CNT_W'(REFRAC_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] sum_sat;
    logic             fire;

    // One extra bit catches the carry so the sum clamps instead of wrapping.
    always_comb begin
        sum_wide = {1'b0, current} + {1'b0, state >> BETA_SHIFT};
        sum_sat  = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
        fire     = (sum_sat >= thresh);
    end

    // NOTE: state flops use non-blocking assignments so every neuron samples
    // the pre-edge values of its own state and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            cnt   <= '0;
            spike <= 1'b0;
        end else if (!step) begin
            spike <= 1'b0;
        end else if (cnt != '0) begin
            cnt   <= cnt - CNT_W'(1);
            state <= '0;
            spike <= 1'b0;
        end else if (fire) begin
            spike <= 1'b1;
            cnt   <= REFRAC_LOAD;
            state <= (mode == LIF_RST_SUB) ? sum_sat - thresh : '0;
        end else begin
            state <= sum_sat;
            spike <= 1'b0;
        end
    end

    assign refrac = (cnt != '0);

endmodule

// File: rtl/lif_array.sv
// Array of N_NEURONS LIF neurons sharing a time-step strobe and a
// runtime-programmable threshold / reset mode.
module lif_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS      = 4,
    parameter int WIDTH          = 8,
    parameter int BETA_SHIFT     = 1,
    parameter int REFRAC_CYCLES  = 2,
    parameter int THRESH_DEFAULT = 127
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step,
    input  logic [N_NEURONS*WIDTH-1:0] current,
    input  logic                       cfg_we,
    input  logic [WIDTH-1:0]           cfg_thresh,
    input  logic                       cfg_mode,
    output logic [N_NEURONS-1:0]       spike,
    output logic [N_NEURONS*WIDTH-1:0] state,
    output logic [N_NEURONS-1:0]       refrac
);

    logic [WIDTH-1:0] thresh_q;
    logic             mode_q;

    // A step coinciding with cfg_we still sees the old values in the neurons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q <= WIDTH'(THRESH_DEFAULT);
            mode_q   <= LIF_RST_ZERO;
        end else if (cfg_we) begin
            thresh_q <= cfg_thresh;
            mode_q   <= cfg_mode;
        end
    end

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        lif_neuron_core #(
            .WIDTH         (WIDTH),
            .BETA_SHIFT    (BETA_SHIFT),
            .REFRAC_CYCLES (REFRAC_CYCLES)
        ) u_core (
            .clk     (clk),
            .rst_n   (rst_n),
            .step    (step),
            .current (current[i*WIDTH +: WIDTH]),
            .thresh  (thresh_q),
            .mode    (mode_q),
            .spike   (spike[i]),
            .state   (state[i*WIDTH +: WIDTH]),
            .refrac  (refrac[i])
        );
    end

endmodule
